uart_tx_arbiter: RTL

- Round-robin arbiter that shares a single UART transmit byte channel between NUM_REQ requesters.
- Each requester offers bytes on a valid/ready stream with a last flag.
- A grant is held until the requester's message completes or a burst limit is reached, so messages from different requesters are not interleaved mid-burst.
- Sits between the requester blocks and the uart_tx byte input inside uart_allocation-style top levels.

---
 rtl/uart_tx_arbiter_if.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 116 +++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle shared by the requesters, the arbiter and uart_tx.
// Requester i drives its byte on s_data_i[i*DATA_W +: DATA_W].
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        s_valid_i;
  logic [NUM_REQ*DATA_W-1:0] s_data_i;
  logic [NUM_REQ-1:0]        s_last_i;
  logic [NUM_REQ-1:0]        s_ready_o;
  logic                      m_valid_o;
  logic [DATA_W-1:0]         m_data_o;
  logic                      m_ready_i;
  logic [NUM_REQ-1:0]        grant_o;
  logic                      busy_o;

  // Arbiter side of the bundle.
  modport slave (
    input  s_valid_i, s_data_i, s_last_i, m_ready_i,
    output s_ready_o, m_valid_o, m_data_o, grant_o, busy_o
  );

  // Requester / uart_tx side of the bundle.
  modport master (
    output s_valid_i, s_data_i, s_last_i, m_ready_i,
    input  s_ready_o, m_valid_o, m_data_o, grant_o, busy_o
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx byte channel between NUM_REQ
// requesters. A grant is held until the owner's last byte or until
// MAX_BURST bytes have moved, then one idle/arbitration cycle follows.
//
// state | meaning
// IDLE  | no owner; pick next requester after the pointer, grant next cycle
// GRANT | owner's stream passed straight through to uart_tx
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input logic              clk_i,
  input logic              areset_i,
  uart_tx_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [DATA_W-1:0] data_arr [NUM_REQ];
  logic [IDX_W-1:0]  pick;
  logic              pick_vld;
  logic              owner_valid;
  logic              owner_last;
  logic              xfer;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_arr[i] = bus.s_data_i[i*DATA_W +: DATA_W];
  end

  assign owner_valid = bus.s_valid_i[owner_q];
  assign owner_last  = bus.s_last_i[owner_q];

  // Round-robin search: first valid requester after the pointer, wrapping.
  always_comb begin
    logic [IDX_W-1:0] cand;
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!pick_vld && bus.s_valid_i[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  // Next state, owner passthrough and burst accounting.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    xfer          = 1'b0;
    bus.m_valid_o = 1'b0;
    bus.m_data_o  = '0;
    bus.s_ready_o = '0;
    bus.grant_o   = '0;
    bus.busy_o    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = GRANT;
          owner_d = pick;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        bus.busy_o             = 1'b1;
        bus.grant_o[owner_q]   = 1'b1;
        bus.s_ready_o[owner_q] = bus.m_ready_i;
        bus.m_valid_o          = owner_valid;
        if (owner_valid) begin
          bus.m_data_o = data_arr[owner_q];
        end
        xfer = owner_valid && bus.m_ready_i;
        if (xfer) begin
          cnt_d = cnt_q + CNT_ONE;
          // Release on end of message or on hitting the burst cap; the
          // pointer moves to the owner so the search resumes after it.
          if (owner_last || (cnt_d == CNT_MAX)) begin
            state_d = IDLE;
            ptr_d   = owner_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset leaves requester 0 with top priority.
  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= PTR_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
